// File: rtl/cmp_pkg.sv
// Shared definitions for the serial comparator: FSM states, result codes
// and counter sizing.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot result codes; bit order matches {gt, lt, eq}.
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_EQ   = 3'b001,
        RES_LT   = 3'b010,
        RES_GT   = 3'b100
    } res_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational STEP-bit unsigned comparator; lt is implied by ~eq & ~gt.
module cmp_chunk #(
    parameter int STEP = 2
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    output logic            eq,
    output logic            gt
);

    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, STEP bits
// per cycle, and exits as soon as a chunk differs.
module serial_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
            $error("serial_comparator: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    state_t           state_reg, state_next;
    res_t             res_reg, res_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] x_reg, y_reg;
    logic             done_reg, done_next;
    logic             load;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] sign_mask;
    assign sign_mask = {sgn, {(WIDTH-1){1'b0}}};

    logic [STEP-1:0] x_chunks [N];
    logic [STEP-1:0] y_chunks [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_chunks
        assign x_chunks[gi] = x_reg[WIDTH-1-gi*STEP -: STEP];
        assign y_chunks[gi] = y_reg[WIDTH-1-gi*STEP -: STEP];
    end

    logic chunk_eq, chunk_gt;

    cmp_chunk #(.STEP(STEP)) u_chunk (
        .a  (x_chunks[cnt_reg]),
        .b  (y_chunks[cnt_reg]),
        .eq (chunk_eq),
        .gt (chunk_gt)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!chunk_eq) begin
                    res_next   = chunk_gt ? RES_GT : RES_LT;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == LAST) begin
                    res_next   = RES_EQ;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            res_reg   <= RES_NONE;
            done_reg  <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
            done_reg  <= done_next;
            if (load) begin
                x_reg <= x ^ sign_mask;
                y_reg <= y ^ sign_mask;
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign eq   = (res_reg == RES_EQ);
    assign lt   = (res_reg == RES_LT);
    assign gt   = (res_reg == RES_GT);

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator (WIDTH=8, STEP=2): directed
// corner cases plus randomized operands against a plain-arithmetic model.
module tb_serial_comparator;

    localparam int WIDTH = 8;
    localparam int STEP  = 2;
    localparam int N     = WIDTH / STEP;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy, done, eq, lt, gt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_comparator #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .lt    (lt),
        .gt    (gt)
    );

    always #5 clk = ~clk;

    // Reference: compare as integers; the deciding chunk is the one holding
    // the most-significant differing bit (sign-bit flipping never changes it).
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, output logic [2:0] egl, output int lat);
        int va, vb;
        va  = s ? int'($signed(a)) : int'(a);
        vb  = s ? int'($signed(b)) : int'(b);
        egl = {va == vb, va < vb, va > vb};
        lat = N;
        for (int bt = WIDTH - 1; bt >= 0; bt--) begin
            if (a[bt] != b[bt]) begin
                lat = (WIDTH - 1 - bt) / STEP + 1;
                break;
            end
        end
    endtask

    // Called at posedge+1: presents one request, then counts edges until done.
    // lat = -1 means done never arrived within the budget.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, output int lat, output bit busy1,
                          output bit overlap);
        start = 1'b1; x = a; y = b; sgn = s;
        @(posedge clk); #1;
        start   = 1'b0;
        x       = WIDTH'($urandom);
        y       = WIDTH'($urandom);
        sgn     = 1'($urandom);
        busy1   = busy;
        overlap = 1'b0;
        lat     = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done && busy) overlap = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
        end
        $display("op x=%h y=%h sgn=%0d -> eq=%0d lt=%0d gt=%0d lat=%0d",
                 a, b, s, eq, lt, gt, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sgn = 1'b0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy, done, eq, lt, gt} !== 5'b0)
            $display("FAIL reset_state actual=%b required=00000", {busy, done, eq, lt, gt});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_equal();
        int lat; bit b1, ov;
        run_op(8'hA5, 8'hA5, 1'b0, lat, b1, ov);
        total_cnt++;
        if (b1 !== 1'b1) $display("FAIL equal_busy_after_start actual=%0d required=1", b1);
        else pass_cnt++;
        total_cnt++;
        if (lat != 4) $display("FAIL equal_latency actual=%0d required=4", lat);
        else pass_cnt++;
        total_cnt++;
        if ({eq, lt, gt} !== 3'b100) $display("FAIL equal_result actual=%b required=100", {eq, lt, gt});
        else pass_cnt++;
    endtask

    task automatic test_msb();
        int lat; bit b1, ov;
        run_op(8'h80, 8'h01, 1'b0, lat, b1, ov);
        total_cnt++;
        if (lat != 1) $display("FAIL msb_unsigned_latency actual=%0d required=1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({eq, lt, gt} !== 3'b001) $display("FAIL msb_unsigned_result actual=%b required=001", {eq, lt, gt});
        else pass_cnt++;
        run_op(8'h80, 8'h01, 1'b1, lat, b1, ov);
        total_cnt++;
        if (lat != 1) $display("FAIL msb_signed_latency actual=%0d required=1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({eq, lt, gt} !== 3'b010) $display("FAIL msb_signed_result actual=%b required=010", {eq, lt, gt});
        else pass_cnt++;
    endtask

    task automatic test_ignore_busy();
        int lat;
        start = 1'b1; x = 8'h12; y = 8'h13; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; x = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        lat = done ? 2 : -1;
        for (int i = 3; i <= 20 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (done) lat = i;
        end
        $display("op x=12 y=13 sgn=0 (start x=ff while busy) -> eq=%0d lt=%0d gt=%0d lat=%0d",
                 eq, lt, gt, lat);
        total_cnt++;
        if (lat != 4) $display("FAIL ignore_latency actual=%0d required=4", lat);
        else pass_cnt++;
        total_cnt++;
        if ({eq, lt, gt} !== 3'b010) $display("FAIL ignore_result actual=%b required=010", {eq, lt, gt});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({busy, done, eq, lt, gt} !== 5'b00010)
            $display("FAIL ignore_no_queue_hold actual=%b required=00010", {busy, done, eq, lt, gt});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; bit b1, ov;
        run_op(8'h3C, 8'h3C, 1'b0, lat, b1, ov);
        total_cnt++;
        if (lat != 4 || {eq, lt, gt} !== 3'b100)
            $display("FAIL b2b_first actual=lat%0d/%b required=lat4/100", lat, {eq, lt, gt});
        else pass_cnt++;
        run_op(8'h01, 8'h00, 1'b0, lat, b1, ov);
        total_cnt++;
        if (b1 !== 1'b1) $display("FAIL b2b_busy_next actual=%0d required=1", b1);
        else pass_cnt++;
        total_cnt++;
        if (lat != 4 || {eq, lt, gt} !== 3'b001)
            $display("FAIL b2b_second actual=lat%0d/%b required=lat4/001", lat, {eq, lt, gt});
        else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        start = 1'b1; x = 8'h5A; y = 8'h5A; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, eq, lt, gt} !== 5'b0)
            $display("FAIL midrun_reset_clear actual=%b required=00000", {busy, done, eq, lt, gt});
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        $display("op reset mid-run x=5a y=5a -> aborted");
        total_cnt++;
        if (saw_done) $display("FAIL midrun_no_done actual=1 required=0");
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, exp_lat; bit b1, ov;
        logic [2:0] exp_egl;
        logic [WIDTH-1:0] a, b;
        logic s;
        for (int i = 0; i < 1000; i++) begin
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 3) == 0) ? (a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)))
                                            : WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            s = 1'($urandom);
            model(a, b, s, exp_egl, exp_lat);
            run_op(a, b, s, lat, b1, ov);
            total_cnt++;
            if ({eq, lt, gt} !== exp_egl)
                $display("FAIL rand_result x=%h y=%h sgn=%0d actual=%b required=%b", a, b, s, {eq, lt, gt}, exp_egl);
            else pass_cnt++;
            total_cnt++;
            if (lat != exp_lat)
                $display("FAIL rand_latency x=%h y=%h sgn=%0d actual=%0d required=%0d", a, b, s, lat, exp_lat);
            else pass_cnt++;
            total_cnt++;
            if (ov) $display("FAIL rand_done_with_busy x=%h y=%h actual=1 required=0", a, b);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (≥2).
REQ-002 SHALL have parameter STEP, default 2, meaning bits compared per cycle; WIDTH % STEP == 0 enforced by elaboration check.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port sgn  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
REQ-007 SHALL have port x  input  WIDTH  left operand; captured with start.
REQ-008 SHALL have port y  input  WIDTH  right operand; captured with start.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port eq  output  1  x == y (registered, held).
REQ-012 SHALL have port lt  output  1  x < y (registered, held).
REQ-013 SHALL have port gt  output  1  x > y (registered, held).

Function
REQ-014 SHALL implement FSM states IDLE, RUN; N = WIDTH/STEP chunks, chunk 0 = most-significant STEP bits.
REQ-015 SHALL, in IDLE with start=1 at an edge, capture x, y, sgn, clear chunk counter to 0, enter RUN; start=0 stays in IDLE.
REQ-016 SHALL, when sgn=1, invert bit WIDTH-1 of both captured operands, so the rest of the datapath is unsigned-only.
REQ-017 SHALL, at each RUN edge, compare chunk[counter] of x and y unsigned.
REQ-018 SHALL, if chunks differ, load gt/lt from that chunk (eq=0), pulse done, return to IDLE (early exit).
REQ-019 SHALL, if chunks equal and counter == N-1, load eq=1, lt=0, gt=0, pulse done, return to IDLE.
REQ-020 SHALL, if chunks equal and counter < N-1, increment counter and stay in RUN.
REQ-021 SHALL give latency: done high in the cycle after the (k+1)-th edge following the start edge, k = index of the deciding chunk; worst case N, best case 1.
REQ-022 SHALL keep exactly one of eq/lt/gt high after the first completion; all three stay stable until the next done.
REQ-023 SHALL ignore start, x, y and sgn while busy=1; no queuing.
REQ-024 SHALL accept start in the same cycle done is high, since the FSM is already in IDLE, giving back-to-back operation with no gap cycle.
REQ-025 SHALL keep busy = (state == RUN); done never coincides with busy=1.

Reset
REQ-026 SHALL, on rst=1, immediately force state IDLE, counter 0, busy 0, done 0, eq 0, lt 0, gt 0, captured operands 0.
REQ-027 SHALL abort an in-flight compare on reset mid-RUN: no done pulse, results cleared.
REQ-028 SHALL sample start on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL place state encodings (IDLE, RUN) and the result-code constants in shared package cmp_pkg.
REQ-030 SHALL use one sub-module, cmp_chunk, a combinational STEP-bit unsigned comparator producing eq and gt; lt = ~eq & ~gt.
REQ-031 SHALL size the counter as clog2(N) bits, minimum 1.

Verification (WIDTH=8, STEP=2)
REQ-032 SHALL cover: x=8'hA5, y=8'hA5, sgn=0 -> done 4 cycles after start, eq=1, lt=0, gt=0.
REQ-033 SHALL cover: x=8'h80, y=8'h01, sgn=0 -> done after 1 cycle, gt=1; same operands with sgn=1 -> done after 1 cycle, lt=1.
REQ-034 SHALL cover: x=8'h12, y=8'h13, sgn=0 -> done after 4 cycles, lt=1; start pulsed with x=8'hFF during busy is ignored and the result is unchanged.
REQ-035 SHALL cover: back-to-back: start re-asserted in the done cycle with x=8'h01, y=8'h00 -> busy the next cycle, then gt=1 after 4 cycles.
REQ-036 SHALL cover: rst asserted during cycle 2 of a 4-cycle compare -> busy, done, eq, lt, gt all 0 immediately; no done pulse follows.
REQ-037 SHALL cover: randomized 1000 operand pairs, both sgn values, against a reference model (results plus latency = deciding chunk index + 1).
